pwm_multichannel_ctrl: RTL and testbench
========================================

# pwm_multichannel_ctrl

Parametrised multi-channel PWM generator that supersedes the fixed 16-channel, 8-bit, single-duty PWM peripheral. It sits behind the SPI peripheral, which drives it through a byte-wide register write port, and its outputs drive the `{uio_out, uo_out}` pins. New behaviour:
- per-channel duty cycle;
- programmable clock prescaler;
- edge- or center-aligned counting;
- duty, prescale and mode shadowed and applied only at period boundaries, so outputs never glitch.

## Interface
Parameters:
- `NUM_CH`, 16, number of channels (1..16).
- `RES`, 8, counter and duty width in bits (4..8). `MAX` = 2^RES−1.

Ports:
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `wr_en` in 1: single-cycle register write strobe.
- `wr_addr` in 7: register address.
- `wr_data` in 8: write data.
- `out` out NUM_CH: PWM outputs. Registered; 0 at reset.
- `period_start` out 1: one-cycle pulse at each period boundary. Registered; 0 at reset.

## Operation
Register map (all registers reset to 0):
- 0x00 / 0x01: `en_out[7:0]` / `en_out[15:8]`.
- 0x02 / 0x03: `en_pwm[7:0]` / `en_pwm[15:8]`.
- 0x04: `prescale`. Shadowed.
- 0x05: `ctrl`. Bit0 = center-aligned mode. Shadowed.
- 0x10+i: `duty[i]`. Uses `wr_data[RES-1:0]`. Shadowed.

Write rules:
- Enable bits at index ≥ NUM_CH are ignored.
- Duty writes with i ≥ NUM_CH are ignored.
- Writes to any other address are ignored.
- A write to a shadowed register updates the shadow copy only.
- Enable registers take effect immediately.

Prescaler:
- `pc` counts 0..`prescale_act`.
- A tick fires when `pc == prescale_act`, and `pc` then returns to 0.
- `prescale_act` = 0 gives a tick every clock.

Counter `cnt` (RES bits) advances only on a tick:
- Edge mode: 0,1,…,MAX then wraps to 0. Period = (MAX+1) ticks.
- Center mode: up 0→MAX, then down MAX→1, then back to 0. A direction flag flips at MAX and at 0. Period = 2·MAX ticks.

Period boundary is the tick on which `cnt` becomes 0. On that edge:
- `duty_act[i]`, `prescale_act` and `mode_act` load from their shadows.
- The direction flag resets to up.
- `pc` resets to 0.
- `period_start` is asserted for the following cycle.

Per-channel comparator, `pwm_i`:
- `duty_act` == 0: 0.
- `duty_act` == MAX: 1.
- Otherwise: `cnt < duty_act`.

Output selection, `out[i]` next value:
- `en_out[i]` = 0: 0.
- `en_out[i]` = 1, `en_pwm[i]` = 0: 1 (static high).
- `en_out[i]` = 1, `en_pwm[i]` = 1: `pwm_i`.

## Timing
- A write is captured on the rising edge where `wr_en` = 1. `wr_en` may be asserted on any cycle, back-to-back.
- Enable write at edge k: `out` reflects it from edge k+1.
- Shadowed write: takes effect at the next period boundary after the write edge. The current period always finishes with its old values.
- If a shadowed write lands on the boundary edge itself, the new value is not loaded at that boundary. It loads at the following one.
- `out` is registered from `cnt`: one clock of latency between a `cnt` change and the matching `out` change. This latency is identical for all channels, so there is no channel-to-channel skew.
- Edge mode high time: `duty` ticks per period.
- Center mode high time: 2·`duty`−1 ticks per period, for 0 < `duty` < MAX. It is centered on `cnt` = 0.
- Reset state: `cnt` = 0, `pc` = 0, direction up, all shadow and active registers 0.
- Reset asserted mid-period: all state clears immediately and asynchronously, and `out` = 0 without waiting for a clock.
- After reset release: counting restarts from 0. The first `period_start` occurs at the first wrap back to 0, not at the release.

## Test plan
Defaults: NUM_CH=16, RES=8.
1. Reset: assert `rst_n`=0 mid-operation → `out` = 0x0000 and `period_start` = 0 immediately. After release, the first `period_start` comes 256 clocks later (prescale 0, edge mode).
2. Static output: write 0x00=0x01 with en_pwm=0 → `out[0]`=1 from the next edge, all other bits 0. Write 0x00=0x00 → `out[0]`=0 on the following edge.
3. Edge PWM: prescale 0, `duty[1]`=0x40, `en_out[1]`=`en_pwm[1]`=1 → `out[1]` high 64 of every 256 clocks. `duty`=0x00 → constant 0; `duty`=0xFF → constant 1.
4. Shadowing: `duty[1]`=0x40 running; write 0x11=0x80 mid-period → the current period stays at 64 high, the next period is 128 high. A write exactly on the boundary edge is deferred by one full period.
5. Center mode and prescaler: `ctrl`=0x01, `duty[2]`=0x40, prescale 0 → period 510 clocks, high 127 clocks centered on `period_start`. Then `prescale`=3 in edge mode → every `cnt` step lasts 4 clocks, period 1024 clocks.
6. Ignored accesses: write 0x10+16=0xFF and 0x06=0xAA → no state changes. With NUM_CH=4: bits 4..15 of the enable registers are ignored, and `out` is 4 bits wide.

Source files
------------

// File: rtl/pwm_multichannel_ctrl.sv
// Multi-channel PWM with per-channel duty, prescaler, edge/center counting and period-boundary shadow loads.
// Outputs lag the counter by one clock; the write port has no backpressure and is accepted every cycle.
module pwm_multichannel_ctrl #(
   parameter int NUM_CH = 16,
   parameter int RES    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [6:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic [NUM_CH-1:0] out,
   output logic              period_start
);
   localparam logic [RES-1:0] MAX = {RES{1'b1}};

   logic [NUM_CH-1:0] r_en_out;
   logic [NUM_CH-1:0] r_en_pwm;
   logic [7:0]        r_prescale_sh;
   logic [7:0]        r_prescale_act;
   logic [7:0]        r_pc;
   logic              r_mode_sh;
   logic              r_mode_act;
   logic              r_dir_down;
   logic [RES-1:0]    r_duty_sh  [NUM_CH];
   logic [RES-1:0]    r_duty_act [NUM_CH];
   logic [RES-1:0]    r_cnt;

   logic [RES-1:0]    w_cnt_nxt;
   logic              w_dir_down_nxt;
   logic              w_tick;
   logic              w_boundary;
   logic [NUM_CH-1:0] w_pwm;
   logic [NUM_CH-1:0] w_out_nxt;

   // Register write port; enables land directly, the rest only in shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_out      <= '0;
         r_en_pwm      <= '0;
         r_prescale_sh <= '0;
         r_mode_sh     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_addr == 7'(i / 8))      r_en_out[i]  <= wr_data[3'(i % 8)];
            if (wr_addr == 7'(2 + i / 8))  r_en_pwm[i]  <= wr_data[3'(i % 8)];
            if (wr_addr == 7'(16 + i))     r_duty_sh[i] <= wr_data[RES-1:0];
         end
         if (wr_addr == 7'h04) r_prescale_sh <= wr_data;
         if (wr_addr == 7'h05) r_mode_sh     <= wr_data[0];
      end
   end

   always_comb begin
      w_cnt_nxt      = r_cnt + RES'(1);
      w_dir_down_nxt = r_dir_down;
      if (r_mode_act) begin
         if (r_dir_down) begin
            w_cnt_nxt = r_cnt - RES'(1);
            if (r_cnt == RES'(1)) w_dir_down_nxt = 1'b0;
         end else if (r_cnt == MAX) begin
            w_cnt_nxt      = r_cnt - RES'(1);
            w_dir_down_nxt = 1'b1;
         end
      end
   end

   assign w_tick     = (r_pc == r_prescale_act);
   assign w_boundary = w_tick && (w_cnt_nxt == '0);

   // A shadow written on the boundary edge itself is not seen here until the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         r_pc           <= '0;
         r_dir_down     <= 1'b0;
         r_prescale_act <= '0;
         r_mode_act     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= '0;
      end else if (w_tick) begin
         r_cnt <= w_cnt_nxt;
         r_pc  <= '0;
         if (w_boundary) begin
            r_dir_down     <= 1'b0;
            r_prescale_act <= r_prescale_sh;
            r_mode_act     <= r_mode_sh;
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty_sh[i];
         end else begin
            r_dir_down <= w_dir_down_nxt;
         end
      end else begin
         r_pc <= r_pc + 8'd1;
      end
   end

   always_comb begin
      w_pwm = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_duty_act[i] == '0)       w_pwm[i] = 1'b0;
         else if (r_duty_act[i] == MAX) w_pwm[i] = 1'b1;
         else                           w_pwm[i] = (r_cnt < r_duty_act[i]);
      end
   end

   assign w_out_nxt = r_en_out & (~r_en_pwm | w_pwm);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         out          <= w_out_nxt;
         period_start <= w_boundary;
      end
   end

endmodule

// File: tb/tb_pwm_multichannel_ctrl.sv
// Scoreboard bench for pwm_multichannel_ctrl: per-period length/high-time measurements and enable latency checks.
module tb_pwm_multichannel_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] out16;
   logic        ps16;
   logic [3:0]  out4;
   logic        ps4;

   int    n_vec = 0;
   int    n_err = 0;
   string tag_q[$];
   int    exp_q[$];

   pwm_multichannel_ctrl #(.NUM_CH(16), .RES(8)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .out(out16), .period_start(ps16)
   );

   pwm_multichannel_ctrl #(.NUM_CH(4), .RES(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .out(out4), .period_start(ps4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input int exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic sb_check(input int got);
      string t = "sb_empty";
      int    e = -1;
      if (tag_q.size() != 0) begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
      end
      chk(t, got, e);
   endtask

   task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Returns at the negedge where period_start is high.
   task automatic wait_ps();
      int found = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (ps16) begin
            found = 1;
            break;
         end
      end
      chk("sync", found, 1);
   endtask

   // Samples one full period starting just after a period_start negedge; optional write at sample wr_at.
   task automatic measure(input int ch, input int wr_at, input logic [6:0] wa, input logic [7:0] wd,
                          output int len, output int hi, output int first, output int last);
      len = 0; hi = 0; first = 0; last = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         wr_en = 1'b0;
         len++;
         if (out16[ch]) hi++;
         if (len == 1) first = int'(out16[ch]);
         last = int'(out16[ch]);
         if (ps16) break;
         if (len == wr_at) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
         end
      end
   endtask

   task automatic expect_period(input string tag, input int ch, input int wr_at,
                                input logic [6:0] wa, input logic [7:0] wd,
                                input int exp_len, input int exp_hi, input int exp_edges);
      int len, hi, first, last;
      sb_push({tag, "_len"}, exp_len);
      sb_push({tag, "_hi"}, exp_hi);
      if (exp_edges >= 0) begin
         sb_push({tag, "_first"}, exp_edges);
         sb_push({tag, "_last"}, exp_edges);
      end
      measure(ch, wr_at, wa, wd, len, hi, first, last);
      sb_check(len);
      sb_check(hi);
      if (exp_edges >= 0) begin
         sb_check(first);
         sb_check(last);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      sb_push("rst_out", 0);  sb_check(int'(out16));
      sb_push("rst_ps", 0);   sb_check(int'(ps16));
      sb_push("rst_ps4", 0);  sb_check(int'(ps4));
      rst_n = 1'b1;

      // Static high on channel 0, one clock after the enable lands.
      write_reg(7'h00, 8'h01);
      sb_push("static_lat", 0);      sb_check(int'(out16));
      @(negedge clk);
      sb_push("static_on", 16'h0001); sb_check(int'(out16));
      write_reg(7'h00, 8'h00);
      @(negedge clk);
      sb_push("static_off", 0);      sb_check(int'(out16));

      // Edge-aligned PWM on channel 1.
      write_reg(7'h11, 8'h40);
      write_reg(7'h00, 8'h02);
      write_reg(7'h02, 8'h02);
      wait_ps();
      expect_period("edge40", 1, -1, 7'h00, 8'h00, 256, 64, -1);
      write_reg(7'h11, 8'h00);
      wait_ps();
      expect_period("duty00", 1, -1, 7'h00, 8'h00, 256, 0, -1);
      write_reg(7'h11, 8'hFF);
      wait_ps();
      expect_period("dutyFF", 1, -1, 7'h00, 8'h00, 256, 256, -1);

      // Shadowing: mid-period write loads next period; boundary-edge write is deferred one period.
      write_reg(7'h11, 8'h40);
      wait_ps();
      expect_period("sh_cur", 1, 10, 7'h11, 8'h80, 256, 64, -1);
      expect_period("sh_nxt", 1, -1, 7'h00, 8'h00, 256, 128, -1);
      expect_period("bd_wr", 1, 255, 7'h11, 8'h20, 256, 128, -1);
      expect_period("bd_hold", 1, -1, 7'h00, 8'h00, 256, 128, -1);
      expect_period("bd_load", 1, -1, 7'h00, 8'h00, 256, 32, -1);

      // Center mode on channel 2, then prescale 3 in edge mode.
      write_reg(7'h05, 8'h01);
      write_reg(7'h12, 8'h40);
      write_reg(7'h00, 8'h04);
      write_reg(7'h02, 8'h04);
      wait_ps();
      expect_period("center", 2, -1, 7'h00, 8'h00, 510, 127, 1);
      write_reg(7'h05, 8'h00);
      write_reg(7'h04, 8'h03);
      wait_ps();
      expect_period("presc3", 2, -1, 7'h00, 8'h00, 1024, 256, -1);
      write_reg(7'h04, 8'h00);
      wait_ps();

      // Out-of-range duty and unmapped address leave behaviour unchanged.
      write_reg(7'h20, 8'hFF);
      write_reg(7'h06, 8'hAA);
      wait_ps();
      expect_period("ignored", 2, -1, 7'h00, 8'h00, 256, 64, -1);

      // Enable masking on the 4-channel instance.
      write_reg(7'h02, 8'h00);
      write_reg(7'h00, 8'hF0);
      write_reg(7'h01, 8'hFF);
      @(negedge clk);
      sb_push("en16_a", 16'hFFF0); sb_check(int'(out16));
      sb_push("en4_a", 0);         sb_check(int'(out4));
      write_reg(7'h00, 8'h0F);
      @(negedge clk);
      sb_push("en16_b", 16'hFF0F); sb_check(int'(out16));
      sb_push("en4_b", 4'hF);      sb_check(int'(out4));

      // Asynchronous reset mid-cycle, then first period_start after release.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb_push("arst_out", 0);  sb_check(int'(out16));
      sb_push("arst_out4", 0); sb_check(int'(out4));
      sb_push("arst_ps", 0);   sb_check(int'(ps16));
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         if (ps16) begin
            n = i;
            break;
         end
      end
      sb_push("first_ps", 256); sb_check(n);
      sb_push("rst_en_clr", 0); sb_check(int'(out16));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
